// File: rtl/rw_sched_pkg.sv
// rw_sched_pkg: shared encodings for the read/write direction scheduler.
// Holds the direction codes, the FSM state encoding and the RAIF num width.
package rw_sched_pkg;

    localparam int RAIF_NUM_W = 10;

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_RD   = 2'b01;
    localparam logic [1:0] DIR_WR   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_BUSY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/rw_sched_pick.sv
// rw_sched_pick: combinational choice of the next transaction direction.
// Write starvation bound first, then read preference from a cold start,
// then batching up to MAX_SAME, then a forced direction swap.
module rw_sched_pick
    import rw_sched_pkg::*;
#(
    parameter int MAX_SAME   = 4,
    parameter int WR_AGE_MAX = 256,
    parameter int SAME_W     = 3,
    parameter int AGE_W      = 9
) (
    input  logic              i_rd_pend,
    input  logic              i_wr_pend,
    input  logic [1:0]        i_last_dir,
    input  logic [SAME_W-1:0] i_same_cnt,
    input  logic [AGE_W-1:0]  i_wr_age,
    output logic [1:0]        o_dir
);

    // Priority-ordered direction choice; NONE when nothing is pending
    always_comb begin
        o_dir = DIR_NONE;
        if (i_rd_pend && !i_wr_pend) begin
            o_dir = DIR_RD;
        end else if (i_wr_pend && !i_rd_pend) begin
            o_dir = DIR_WR;
        end else if (i_rd_pend && i_wr_pend) begin
            if (i_wr_age == AGE_W'(WR_AGE_MAX))
                o_dir = DIR_WR;
            else if (i_last_dir == DIR_NONE)
                o_dir = DIR_RD;
            else if (i_same_cnt < SAME_W'(MAX_SAME))
                o_dir = i_last_dir;
            else
                o_dir = (i_last_dir == DIR_RD) ? DIR_WR : DIR_RD;
        end
    end

endmodule

// File: rtl/rw_sched.sv
// rw_sched: read/write direction scheduler in front of a single ddr3_core.
// Batches same-direction transactions, inserts TURN_CYC idle cycles on a
// direction change and bounds write starvation with a saturating age counter.
// Optional feature macro RW_SCHED_CHK_EN: beat-count checker driving chk_err.
module rw_sched
    import rw_sched_pkg::*;
#(
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_ADDR_WIDTH = 28,
    parameter int MAX_SAME       = 4,
    parameter int WR_AGE_MAX     = 256,
    parameter int TURN_CYC       = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_rd_req,
    input  logic [APP_ADDR_WIDTH-1:0] s_rd_addr,
    input  logic [RAIF_NUM_W-1:0]     s_rd_num,
    output logic                      s_rd_grant,
    output logic [APP_DATA_WIDTH-1:0] s_rd_data,
    output logic                      s_rd_finish,
    input  logic                      s_wr_req,
    input  logic [APP_ADDR_WIDTH-1:0] s_wr_addr,
    input  logic [RAIF_NUM_W-1:0]     s_wr_num,
    input  logic [APP_DATA_WIDTH-1:0] s_wr_data,
    output logic                      s_wr_grant,
    output logic                      s_wr_finish,
    output logic                      m_rd_req,
    output logic [APP_ADDR_WIDTH-1:0] m_rd_addr,
    output logic [RAIF_NUM_W-1:0]     m_rd_num,
    input  logic                      m_rd_grant,
    input  logic [APP_DATA_WIDTH-1:0] m_rd_data,
    input  logic                      m_rd_finish,
    output logic                      m_wr_req,
    output logic [APP_ADDR_WIDTH-1:0] m_wr_addr,
    output logic [RAIF_NUM_W-1:0]     m_wr_num,
    output logic [APP_DATA_WIDTH-1:0] m_wr_data,
    input  logic                      m_wr_grant,
    input  logic                      m_wr_finish,
    output logic [1:0]                busy_dir,
    output logic                      chk_err
);

    localparam int SAME_W = $clog2(MAX_SAME + 1);
    localparam int AGE_W  = $clog2(WR_AGE_MAX + 1);
    localparam int TURN_W = $clog2(TURN_CYC + 1);

    state_t            r_state;
    logic [1:0]        r_sel;
    logic [1:0]        r_last_dir;
    logic [1:0]        r_busy_dir;
    logic [SAME_W-1:0] r_same_cnt;
    logic [AGE_W-1:0]  r_wr_age;
    logic [TURN_W-1:0] r_turn_cnt;

    logic [1:0] w_pick;
    logic       w_fwd_rd;
    logic       w_fwd_wr;
    logic       w_fin;
    logic       w_need_turn;
    logic       w_turn_done;
    logic       w_idle_to_busy;
    logic       w_enter_wr;

    rw_sched_pick #(
        .MAX_SAME   (MAX_SAME),
        .WR_AGE_MAX (WR_AGE_MAX),
        .SAME_W     (SAME_W),
        .AGE_W      (AGE_W)
    ) u_pick (
        .i_rd_pend  (s_rd_req),
        .i_wr_pend  (s_wr_req),
        .i_last_dir (r_last_dir),
        .i_same_cnt (r_same_cnt),
        .i_wr_age   (r_wr_age),
        .o_dir      (w_pick)
    );

    // Forwarding only ever opens for the selected side while BUSY, so an
    // async reset closes every path in the same instant.
    assign w_fwd_rd       = (r_state == ST_BUSY) && (r_sel == DIR_RD);
    assign w_fwd_wr       = (r_state == ST_BUSY) && (r_sel == DIR_WR);
    assign w_fin          = (w_fwd_rd && m_rd_finish) || (w_fwd_wr && m_wr_finish);
    assign w_need_turn    = (r_last_dir != DIR_NONE) && (w_pick != r_last_dir);
    assign w_turn_done    = (r_state == ST_TURN) && (r_turn_cnt == TURN_W'(TURN_CYC - 1));
    assign w_idle_to_busy = (r_state == ST_IDLE) && (w_pick != DIR_NONE) && !w_need_turn;
    assign w_enter_wr     = (w_idle_to_busy && (w_pick == DIR_WR)) ||
                            (w_turn_done && (r_sel == DIR_WR));

    assign m_rd_req    = w_fwd_rd && s_rd_req;
    assign m_rd_addr   = w_fwd_rd ? s_rd_addr : '0;
    assign m_rd_num    = w_fwd_rd ? s_rd_num  : '0;
    assign s_rd_grant  = w_fwd_rd && m_rd_grant;
    assign s_rd_data   = w_fwd_rd ? m_rd_data : '0;
    assign s_rd_finish = w_fwd_rd && m_rd_finish;

    assign m_wr_req    = w_fwd_wr && s_wr_req;
    assign m_wr_addr   = w_fwd_wr ? s_wr_addr : '0;
    assign m_wr_num    = w_fwd_wr ? s_wr_num  : '0;
    assign m_wr_data   = w_fwd_wr ? s_wr_data : '0;
    assign s_wr_grant  = w_fwd_wr && m_wr_grant;
    assign s_wr_finish = w_fwd_wr && m_wr_finish;

    assign busy_dir = r_busy_dir;

    // Scheduler FSM: pick in IDLE, optional turnaround, forward, one dead cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sel      <= DIR_NONE;
            r_last_dir <= DIR_NONE;
            r_busy_dir <= DIR_NONE;
            r_same_cnt <= '0;
            r_turn_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick != DIR_NONE) begin
                        r_sel <= w_pick;
                        if (w_need_turn) begin
                            r_state    <= ST_TURN;
                            r_turn_cnt <= '0;
                        end else begin
                            r_state    <= ST_BUSY;
                            r_busy_dir <= w_pick;
                        end
                    end
                end
                ST_TURN: begin
                    if (w_turn_done) begin
                        r_state    <= ST_BUSY;
                        r_busy_dir <= r_sel;
                    end else begin
                        r_turn_cnt <= r_turn_cnt + TURN_W'(1);
                    end
                end
                ST_BUSY: begin
                    if (w_fin) begin
                        r_state    <= ST_DONE;
                        r_busy_dir <= DIR_NONE;
                        r_last_dir <= r_sel;
                        if (r_sel != r_last_dir)
                            r_same_cnt <= SAME_W'(1);
                        else if (r_same_cnt != SAME_W'(MAX_SAME))
                            r_same_cnt <= r_same_cnt + SAME_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Write age: counts waiting cycles, saturates, restarts when a write begins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_age <= '0;
        end else if (w_enter_wr) begin
            r_wr_age <= '0;
        end else if (s_wr_req && !w_fwd_wr && (r_wr_age != AGE_W'(WR_AGE_MAX))) begin
            r_wr_age <= r_wr_age + AGE_W'(1);
        end
    end

`ifdef RW_SCHED_CHK_EN
    logic [10:0] r_beat_cnt;
    logic        r_chk_err;
    logic        w_grant;
    logic [10:0] w_beats;
    logic [RAIF_NUM_W-1:0] w_num;

    // A grant coinciding with finish still belongs to this transaction
    assign w_grant = (w_fwd_rd && m_rd_grant) || (w_fwd_wr && m_wr_grant);
    assign w_beats = r_beat_cnt + 11'(w_grant);
    assign w_num   = w_fwd_rd ? s_rd_num : s_wr_num;

    // Beat counter compared with the requested num at finish; error is sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_chk_err  <= 1'b0;
        end else if (w_fin) begin
            r_beat_cnt <= '0;
            if (w_beats != 11'(w_num))
                r_chk_err <= 1'b1;
        end else if (r_state != ST_BUSY) begin
            r_beat_cnt <= '0;
        end else if (w_grant) begin
            r_beat_cnt <= w_beats;
        end
    end

    assign chk_err = r_chk_err;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_rw_sched.sv
// tb_rw_sched: directed bench for rw_sched with a scripted ddr3_core model.
// DUT built with MAX_SAME=4, WR_AGE_MAX=16, TURN_CYC=2.
module tb_rw_sched;
    import rw_sched_pkg::*;

    localparam int DW = 128;
    localparam int AW = 28;

`ifdef RW_SCHED_CHK_EN
    localparam logic CHK_EXP = 1'b1;
`else
    localparam logic CHK_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_rd_req = 1'b0;
    logic [AW-1:0] s_rd_addr = '0;
    logic [9:0]    s_rd_num = '0;
    logic          s_rd_grant;
    logic [DW-1:0] s_rd_data;
    logic          s_rd_finish;
    logic          s_wr_req = 1'b0;
    logic [AW-1:0] s_wr_addr = '0;
    logic [9:0]    s_wr_num = '0;
    logic [DW-1:0] s_wr_data = '0;
    logic          s_wr_grant;
    logic          s_wr_finish;
    logic          m_rd_req;
    logic [AW-1:0] m_rd_addr;
    logic [9:0]    m_rd_num;
    logic          m_rd_grant = 1'b0;
    logic [DW-1:0] m_rd_data = '0;
    logic          m_rd_finish = 1'b0;
    logic          m_wr_req;
    logic [AW-1:0] m_wr_addr;
    logic [9:0]    m_wr_num;
    logic [DW-1:0] m_wr_data;
    logic          m_wr_grant = 1'b0;
    logic          m_wr_finish = 1'b0;
    logic [1:0]    busy_dir;
    logic          chk_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t_mark = 0;

    rw_sched #(
        .APP_DATA_WIDTH (DW),
        .APP_ADDR_WIDTH (AW),
        .MAX_SAME       (4),
        .WR_AGE_MAX     (16),
        .TURN_CYC       (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_rd_req    (s_rd_req),
        .s_rd_addr   (s_rd_addr),
        .s_rd_num    (s_rd_num),
        .s_rd_grant  (s_rd_grant),
        .s_rd_data   (s_rd_data),
        .s_rd_finish (s_rd_finish),
        .s_wr_req    (s_wr_req),
        .s_wr_addr   (s_wr_addr),
        .s_wr_num    (s_wr_num),
        .s_wr_data   (s_wr_data),
        .s_wr_grant  (s_wr_grant),
        .s_wr_finish (s_wr_finish),
        .m_rd_req    (m_rd_req),
        .m_rd_addr   (m_rd_addr),
        .m_rd_num    (m_rd_num),
        .m_rd_grant  (m_rd_grant),
        .m_rd_data   (m_rd_data),
        .m_rd_finish (m_rd_finish),
        .m_wr_req    (m_wr_req),
        .m_wr_addr   (m_wr_addr),
        .m_wr_num    (m_wr_num),
        .m_wr_data   (m_wr_data),
        .m_wr_grant  (m_wr_grant),
        .m_wr_finish (m_wr_finish),
        .busy_dir    (busy_dir),
        .chk_err     (chk_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the falling edge
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_rd_req = 1'b0; s_wr_req = 1'b0;
        m_rd_grant = 1'b0; m_wr_grant = 1'b0;
        m_rd_finish = 1'b0; m_wr_finish = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Core model: wait for a forwarded request, give nbeats grants, then finish.
    // lat is the number of clock edges since t_mark.
    task automatic serve(input int nbeats, input bit raise_wr, output logic [1:0] dir, output int lat);
        int waited = 0;
        #1;
        while (!(m_rd_req || m_wr_req) && waited < 40) begin
            tick();
            waited++;
        end
        lat = cyc - t_mark;
        dir = m_rd_req ? DIR_RD : (m_wr_req ? DIR_WR : DIR_NONE);
        if (dir == DIR_NONE) begin
            check_val("req_timeout", 1'b0, 1'b1);
            return;
        end
        check_val("busy_dir_busy", busy_dir, dir);
        if (dir == DIR_RD) check_val("rd_addr_fwd", m_rd_addr, s_rd_addr);
        else               check_val("wr_addr_fwd", m_wr_addr, s_wr_addr);
        for (int i = 0; i < nbeats; i++) begin
            if (dir == DIR_RD) begin
                m_rd_grant = 1'b1;
                m_rd_data  = {4{32'hA500_0000 + 32'(i)}};
                #1;
                check_val("rd_grant", s_rd_grant, 1'b1);
                check_val("rd_data", s_rd_data, {4{32'hA500_0000 + 32'(i)}});
                check_val("wr_grant_idle", s_wr_grant, 1'b0);
            end else begin
                m_wr_grant = 1'b1;
                #1;
                check_val("wr_grant", s_wr_grant, 1'b1);
                check_val("wr_data_fwd", m_wr_data, s_wr_data);
                check_val("rd_grant_idle", s_rd_grant, 1'b0);
            end
            tick();
            m_rd_grant = 1'b0;
            m_wr_grant = 1'b0;
        end
        if (dir == DIR_RD) m_rd_finish = 1'b1;
        else               m_wr_finish = 1'b1;
        if (raise_wr) s_wr_req = 1'b1;
        #1;
        if (dir == DIR_RD) check_val("rd_finish", s_rd_finish, 1'b1);
        else               check_val("wr_finish", s_wr_finish, 1'b1);
        t_mark = cyc;
        tick();
        m_rd_finish = 1'b0;
        m_wr_finish = 1'b0;
    endtask

    logic [1:0] dir;
    int         lat;
    logic [1:0] exp_dir2 [9] = '{DIR_RD, DIR_RD, DIR_RD, DIR_RD, DIR_WR, DIR_WR, DIR_WR, DIR_WR, DIR_RD};
    int         exp_lat2 [9] = '{1, 3, 3, 3, 5, 3, 3, 3, 5};

    initial begin
        // Reset state
        do_reset();
        check_val("rst_busy_dir", busy_dir, 2'b00);
        check_val("rst_chk_err", chk_err, 1'b0);
        check_val("rst_m_rd_req", m_rd_req, 1'b0);
        check_val("rst_m_wr_req", m_wr_req, 1'b0);

        // Read only, 8 beats, no turnaround
        s_rd_addr = 28'h0123456;
        s_rd_num  = 10'd8;
        s_rd_req  = 1'b1;
        t_mark = cyc;
        serve(8, 1'b0, dir, lat);
        check_val("t1_dir", dir, DIR_RD);
        check_val("t1_lat", lat, 1);
        check_val("t1_busy_dir_done", busy_dir, 2'b00);
        s_rd_req = 1'b0;
        tick();
        tick();
        check_val("t1_no_reissue", m_rd_req, 1'b0);

        // Finish outside BUSY is ignored
        m_rd_finish = 1'b1;
        #1;
        check_val("stray_finish", s_rd_finish, 1'b0);
        tick();
        m_rd_finish = 1'b0;
        check_val("stray_busy_dir", busy_dir, 2'b00);

        // Both held: batches of 4 with turnaround gaps
        do_reset();
        s_rd_num = 10'd1; s_wr_num = 10'd1;
        s_rd_addr = 28'h0000100; s_wr_addr = 28'h0000200;
        s_wr_data = {4{32'h5A5A_0001}};
        s_rd_req = 1'b1;
        t_mark = cyc;
        tick();
        s_wr_req = 1'b1;
        for (int k = 0; k < 9; k++) begin
            serve(1, 1'b0, dir, lat);
            check_val($sformatf("t2_dir%0d", k), dir, exp_dir2[k]);
            check_val($sformatf("t2_lat%0d", k), lat, exp_lat2[k]);
        end
        s_rd_req = 1'b0; s_wr_req = 1'b0;

        // Write forced by age while the read batch is still short
        do_reset();
        s_rd_num = 10'd8; s_wr_num = 10'd1;
        s_rd_req = 1'b1; s_wr_req = 1'b1;
        t_mark = cyc;
        serve(8, 1'b0, dir, lat);
        check_val("t3_dir0", dir, DIR_RD);
        serve(8, 1'b0, dir, lat);
        check_val("t3_dir1", dir, DIR_RD);
        check_val("t3_lat1", lat, 3);
        serve(1, 1'b0, dir, lat);
        check_val("t3_dir2", dir, DIR_WR);
        check_val("t3_lat2", lat, 5);
        s_rd_req = 1'b0; s_wr_req = 1'b0;

        // New request in the finish cycle waits through DONE and TURN
        do_reset();
        s_rd_num = 10'd2; s_wr_num = 10'd1;
        s_rd_req = 1'b1;
        t_mark = cyc;
        serve(2, 1'b1, dir, lat);
        check_val("t4_dir0", dir, DIR_RD);
        s_rd_req = 1'b0;
        check_val("t4_done_quiet", m_wr_req, 1'b0);
        serve(1, 1'b0, dir, lat);
        check_val("t4_dir1", dir, DIR_WR);
        check_val("t4_lat1", lat, 5);
        s_wr_req = 1'b0;

        // Reset during a write, then cold-start pick prefers read
        do_reset();
        s_wr_num = 10'd4; s_wr_addr = 28'h0ABCDEF;
        s_wr_req = 1'b1;
        tick();
        check_val("t5_m_wr_req", m_wr_req, 1'b1);
        m_wr_grant = 1'b1;
        #1;
        check_val("t5_grant_before", s_wr_grant, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_m_wr_req", m_wr_req, 1'b0);
        check_val("t5_rst_s_wr_grant", s_wr_grant, 1'b0);
        check_val("t5_rst_m_wr_addr", m_wr_addr, '0);
        check_val("t5_rst_busy_dir", busy_dir, 2'b00);
        m_wr_grant = 1'b0;
        tick();
        tick();
        s_rd_num = 10'd1; s_wr_num = 10'd1;
        rst_n = 1'b1;
        s_rd_req = 1'b1;
        t_mark = cyc;
        serve(1, 1'b0, dir, lat);
        check_val("t5_dir_after", dir, DIR_RD);
        check_val("t5_lat_after", lat, 1);
        s_rd_req = 1'b0; s_wr_req = 1'b0;

        // Beat-count checker: short transaction sets a sticky error
        do_reset();
        check_val("t6_chk_clear", chk_err, 1'b0);
        s_rd_num = 10'd4;
        s_rd_req = 1'b1;
        t_mark = cyc;
        serve(3, 1'b0, dir, lat);
        s_rd_req = 1'b0;
        check_val("t6_chk_set", chk_err, CHK_EXP);
        tick();
        s_rd_num = 10'd2;
        s_rd_req = 1'b1;
        t_mark = cyc;
        serve(2, 1'b0, dir, lat);
        s_rd_req = 1'b0;
        tick();
        check_val("t6_chk_sticky", chk_err, CHK_EXP);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
